// File: rtl/irqctrl_prio_pkg.sv
// irqctrl_prio shared definitions: register offsets, SRCCFG fields,
// claim response codes and the per-slot flag bundle.
package irqctrl_prio_pkg;

    localparam int REG_DSTEN  = 0;
    localparam int REG_SRCSEL = 1;
    localparam int REG_SRCCFG = 2;
    localparam int REG_IPI    = 3;
    localparam int REG_CLAIM  = 4;

    localparam int CFG_EN   = 0;
    localparam int CFG_EDGE = 1;
    localparam int CFG_PRIO = 2;

    localparam int RSP_IPI  = -1;
    localparam int RSP_IDLE = -2;

    typedef struct packed {
        logic vld;
        logic clm;
        logic ipi;
    } slot_flags_t;

    function automatic int idxw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irqctrl_prio_arb.sv
// Combinational arbiter: highest priority requester wins,
// lowest index breaks ties.
module irqctrl_prio_arb #(
    parameter int N  = 8,
    parameter int PW = 2,
    parameter int IW = 3
) (
    input  logic [N-1:0]    req_i,
    input  logic [N*PW-1:0] prio_i,
    output logic [IW-1:0]   idx_o,
    output logic            vld_o
);

    logic [PW-1:0] best;

    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        best  = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && (!vld_o || prio_i[i*PW +: PW] > best)) begin
                vld_o = 1'b1;
                idx_o = IW'(i);
                best  = prio_i[i*PW +: PW];
            end
        end
    end

endmodule

// File: rtl/irqctrl_prio.sv
// Prioritised multi-dispatch interrupt controller: one dispatch slot
// per destination, register-mapped configuration and claim/complete.
module irqctrl_prio
    import irqctrl_prio_pkg::*;
#(
    parameter int ARCHBITSZ   = 32,
    parameter int IRQSRCCOUNT = 8,
    parameter int IRQDSTCOUNT = 2,
    parameter int PRIOBITSZ   = 2,
    localparam int ADDRBITSZ  = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [ADDRBITSZ-1:0]   wb_addr_i,
    input  logic [ARCHBITSZ/8-1:0] wb_sel_i,
    input  logic [ARCHBITSZ-1:0]   wb_dat_i,
    output logic                   wb_bsy_o,
    output logic                   wb_ack_o,
    output logic [ARCHBITSZ-1:0]   wb_dat_o,
    output logic [ARCHBITSZ-1:0]   wb_mapsz_o,
    output logic [IRQDSTCOUNT-1:0] irq_dst_stb_o,
    input  logic [IRQDSTCOUNT-1:0] irq_dst_rdy_i,
    input  logic [IRQDSTCOUNT-1:0] irq_dst_pri_i,
    input  logic [IRQSRCCOUNT-1:0] irq_src_stb_i,
    output logic [IRQSRCCOUNT-1:0] irq_src_rdy_o
);

    localparam int S     = IRQSRCCOUNT;
    localparam int D     = IRQDSTCOUNT;
    localparam int PW    = PRIOBITSZ;
    localparam int ABITS = $clog2(4 + D);
    localparam int SW    = idxw(S);
    localparam int DW    = idxw(D);

    logic             req, wr, rd;
    logic [ABITS-1:0] off;
    logic             unused_ok;

    logic                 ack_q, ack_d;
    logic [ARCHBITSZ-1:0] dat_q, dat_d;
    logic [D-1:0]         dsten_q, dsten_d;
    logic [SW-1:0]        srcsel_q, srcsel_d;
    logic [S-1:0]         en_q, en_d;
    logic [S-1:0]         edge_q, edge_d;
    logic [S*PW-1:0]      prio_q, prio_d;
    logic [S-1:0]         stbp_q, stbp_d;
    logic [S-1:0]         latch_q, latch_d;
    logic [D-1:0]         ipipend_q, ipipend_d;
    slot_flags_t          slot_q [D];
    slot_flags_t          slot_d [D];
    logic [SW-1:0]        sidx_q [D];
    logic [SW-1:0]        sidx_d [D];

    logic [S-1:0]         inflight, latch_eff, pending;
    logic [D-1:0]         free, dst_req;
    logic [SW-1:0]        src_idx;
    logic                 src_vld;
    logic [DW-1:0]        dst_idx;
    logic                 dst_vld;
    logic [DW-1:0]        ipi_idx;
    logic                 ipi_vld;
    logic [ARCHBITSZ-1:0] cfg_rd;

    assign req = wb_cyc_i & wb_stb_i;
    assign wr  = req & wb_we_i;
    assign rd  = req & ~wb_we_i;
    assign off = wb_addr_i[ABITS-1:0];

    assign unused_ok = ^{wb_sel_i, wb_addr_i[ADDRBITSZ-1:ABITS]};

    always_comb begin
        inflight = '0;
        ipi_vld  = 1'b0;
        ipi_idx  = '0;
        for (int d = 0; d < D; d++) begin
            free[d] = ~slot_q[d].vld;
            for (int s = 0; s < S; s++) begin
                if (slot_q[d].vld && !slot_q[d].ipi && sidx_q[d] == SW'(s))
                    inflight[s] = 1'b1;
            end
        end
        for (int d = D - 1; d >= 0; d--) begin
            if (ipipend_q[d] && free[d]) begin
                ipi_vld = 1'b1;
                ipi_idx = DW'(d);
            end
        end
    end

    // A rising edge seen this cycle counts as latched, so edge sources
    // dispatch with the same one-cycle latency as level sources.
    assign latch_eff = latch_q | (irq_src_stb_i & ~stbp_q);
    assign pending   = en_q & ~inflight &
                       ((edge_q & latch_eff) | (~edge_q & irq_src_stb_i));
    assign dst_req   = free & dsten_q & irq_dst_rdy_i;

    irqctrl_prio_arb #(
        .N (S),
        .PW(PW),
        .IW(SW)
    ) u_src_arb (
        .req_i (pending),
        .prio_i(prio_q),
        .idx_o (src_idx),
        .vld_o (src_vld)
    );

    irqctrl_prio_arb #(
        .N (D),
        .PW(1),
        .IW(DW)
    ) u_dst_arb (
        .req_i (dst_req),
        .prio_i(irq_dst_pri_i),
        .idx_o (dst_idx),
        .vld_o (dst_vld)
    );

    always_comb begin
        cfg_rd = '0;
        for (int s = 0; s < S; s++) begin
            if (srcsel_q == SW'(s)) begin
                cfg_rd[CFG_EN]          = en_q[s];
                cfg_rd[CFG_EDGE]        = edge_q[s];
                cfg_rd[CFG_PRIO +: PW]  = prio_q[s*PW +: PW];
                cfg_rd[ARCHBITSZ-1]     = pending[s];
            end
        end
    end

    always_comb begin
        ack_d     = req;
        dat_d     = '0;
        dsten_d   = dsten_q;
        srcsel_d  = srcsel_q;
        en_d      = en_q;
        edge_d    = edge_q;
        prio_d    = prio_q;
        stbp_d    = irq_src_stb_i;
        latch_d   = latch_eff;
        ipipend_d = ipipend_q;
        slot_d    = slot_q;
        sidx_d    = sidx_q;

        if (ipi_vld) begin
            for (int d = 0; d < D; d++) begin
                if (ipi_idx == DW'(d)) begin
                    slot_d[d]    = '{vld: 1'b1, clm: 1'b0, ipi: 1'b1};
                    ipipend_d[d] = 1'b0;
                end
            end
        end else if (src_vld && dst_vld) begin
            for (int d = 0; d < D; d++) begin
                if (dst_idx == DW'(d)) begin
                    slot_d[d] = '{vld: 1'b1, clm: 1'b0, ipi: 1'b0};
                    sidx_d[d] = src_idx;
                end
            end
            for (int s = 0; s < S; s++) begin
                if (src_idx == SW'(s))
                    latch_d[s] = 1'b0;
            end
        end

        if (wr) begin
            case (off)
                ABITS'(REG_DSTEN): dsten_d = wb_dat_i[D-1:0];
                ABITS'(REG_SRCSEL): begin
                    if (wb_dat_i < ARCHBITSZ'(S))
                        srcsel_d = wb_dat_i[SW-1:0];
                end
                ABITS'(REG_SRCCFG): begin
                    for (int s = 0; s < S; s++) begin
                        if (srcsel_q == SW'(s)) begin
                            en_d[s]             = wb_dat_i[CFG_EN];
                            edge_d[s]           = wb_dat_i[CFG_EDGE];
                            prio_d[s*PW +: PW]  = wb_dat_i[CFG_PRIO +: PW];
                        end
                    end
                end
                ABITS'(REG_IPI): begin
                    for (int d = 0; d < D; d++) begin
                        if (wb_dat_i == ARCHBITSZ'(d))
                            ipipend_d[d] = 1'b1;
                    end
                end
                default: begin
                    for (int d = 0; d < D; d++) begin
                        if (off == ABITS'(REG_CLAIM + d) && slot_q[d].vld)
                            slot_d[d] = '0;
                    end
                end
            endcase
        end

        if (rd) begin
            case (off)
                ABITS'(REG_DSTEN):  dat_d = ARCHBITSZ'(dsten_q);
                ABITS'(REG_SRCSEL): dat_d = ARCHBITSZ'(srcsel_q);
                ABITS'(REG_SRCCFG): dat_d = cfg_rd;
                ABITS'(REG_IPI):    dat_d = ARCHBITSZ'(ipipend_q);
                default: begin
                    for (int d = 0; d < D; d++) begin
                        if (off == ABITS'(REG_CLAIM + d)) begin
                            if (slot_q[d].vld && !slot_q[d].clm) begin
                                dat_d         = slot_q[d].ipi ?
                                                ARCHBITSZ'(RSP_IPI) :
                                                ARCHBITSZ'(sidx_q[d]);
                                slot_d[d].clm = 1'b1;
                            end else begin
                                dat_d = ARCHBITSZ'(RSP_IDLE);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            dsten_q   <= '0;
            srcsel_q  <= '0;
            en_q      <= '0;
            edge_q    <= '0;
            prio_q    <= '0;
            stbp_q    <= '0;
            latch_q   <= '0;
            ipipend_q <= '0;
            slot_q    <= '{default: '0};
            sidx_q    <= '{default: '0};
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            dsten_q   <= dsten_d;
            srcsel_q  <= srcsel_d;
            en_q      <= en_d;
            edge_q    <= edge_d;
            prio_q    <= prio_d;
            stbp_q    <= stbp_d;
            latch_q   <= latch_d;
            ipipend_q <= ipipend_d;
            slot_q    <= slot_d;
            sidx_q    <= sidx_d;
        end
    end

    always_comb begin
        for (int d = 0; d < D; d++)
            irq_dst_stb_o[d] = slot_q[d].vld & ~slot_q[d].clm;
    end

    assign irq_src_rdy_o = ~inflight;
    assign wb_bsy_o      = 1'b0;
    assign wb_ack_o      = ack_q;
    assign wb_dat_o      = dat_q;
    assign wb_mapsz_o    = ARCHBITSZ'((1 << ABITS) * (ARCHBITSZ / 8));

endmodule
